// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: reassembles LSB-first data frames, checks the trailing
// parity bit in even or odd mode, and keeps a saturating error count plus a sticky LED.
module parity_frame_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ODD    = 0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              frame_valid,
  output logic              par_err,
  output logic              abort,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              led
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                fv_q, fv_d;
  logic                perr_q, perr_d;
  logic                abort_q, abort_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                led_q, led_d;
  logic                bad;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      perr_q  <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      perr_q  <= perr_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  // Next-state logic; a sof always (re)starts a frame in DATA
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      if (sof) begin
        state_d = DATA;
      end else begin
        unique case (state_q)
          DATA:    if (cnt_q == CW'(DATA_W - 1)) state_d = PAR;
          PAR:     state_d = IDLE;
          default: state_d = state_q;
        endcase
      end
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fv_d    = 1'b0;
    abort_d = 1'b0;
    err_d   = err_q;
    led_d   = led_q;
    bad     = 1'b0;
    if (bit_valid && sof) begin
      shift_d = DATA_W'(bit_in);
      cnt_d   = CW'(1);
      abort_d = (state_q != IDLE);
    end else if (bit_valid) begin
      unique case (state_q)
        DATA: begin
          shift_d = shift_q | (DATA_W'(bit_in) << cnt_q);
          cnt_d   = cnt_q + CW'(1);
        end
        PAR: begin
          bad    = (^shift_q ^ 1'(ODD)) != bit_in;
          data_d = shift_q;
          perr_d = bad;
          fv_d   = 1'b1;
        end
        default: ;
      endcase
    end
    // A clear coinciding with an error leaves exactly that one error counted
    if (clr_err) begin
      err_d = bad ? CNT_W'(1) : '0;
      led_d = bad;
    end else if (bad) begin
      err_d = (err_q == '1) ? err_q : err_q + CNT_W'(1);
      led_d = 1'b1;
    end
  end

  assign data_out    = data_q;
  assign frame_valid = fv_q;
  assign par_err     = perr_q;
  assign abort       = abort_q;
  assign err_cnt     = err_q;
  assign led         = led_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: three instances (even/8-bit count, odd, even/2-bit count)
// share one directed stimulus and are checked every cycle against a frame-level model.
module tb_parity_frame_checker;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bit_in = 1'b0, bit_valid = 1'b0, sof = 1'b0, clr_err = 1'b0;

  logic [7:0] d0, d1, d2;
  logic       fv0, fv1, fv2, pe0, pe1, pe2, ab0, ab1, ab2, led0, led1, led2;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(8), .ODD(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .clr_err(clr_err), .data_out(d0), .frame_valid(fv0), .par_err(pe0), .abort(ab0),
    .err_cnt(ec0), .led(led0));
  parity_frame_checker #(.DATA_W(8), .ODD(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .clr_err(clr_err), .data_out(d1), .frame_valid(fv1), .par_err(pe1), .abort(ab1),
    .err_cnt(ec1), .led(led1));
  parity_frame_checker #(.DATA_W(8), .ODD(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .clr_err(clr_err), .data_out(d2), .frame_valid(fv2), .par_err(pe2), .abort(ab2),
    .err_cnt(ec2), .led(led2));

  // Frame-level model: collected data value, ones count, and error bookkeeping
  typedef struct {
    bit active; int n; int data; int ones;
    int dout; bit fv; bit perr; bit abort; int cnt; bit led;
  } m_t;

  m_t m0, m1, m2;

  function automatic m_t m_step(m_t m, int odd, int cmax, bit bv, bit b, bit s, bit clr);
    bit err;
    err = 1'b0;
    m.fv = 1'b0;
    m.abort = 1'b0;
    if (bv && s) begin
      m.abort = m.active;
      m.active = 1'b1;
      m.n = 1;
      m.data = int'(b);
      m.ones = int'(b);
    end else if (bv && m.active) begin
      if (m.n < int'(DW)) begin
        m.data = m.data + (int'(b) << m.n);
        m.ones = m.ones + int'(b);
        m.n = m.n + 1;
      end else begin
        m.ones = m.ones + int'(b);
        err = (m.ones % 2) != odd;
        m.dout = m.data;
        m.perr = err;
        m.fv = 1'b1;
        m.active = 1'b0;
      end
    end
    if (clr) begin
      m.cnt = err ? 1 : 0;
      m.led = err;
    end else if (err) begin
      m.cnt = (m.cnt < cmax) ? m.cnt + 1 : cmax;
      m.led = 1'b1;
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = '{default: 0};
      m1 = '{default: 0};
      m2 = '{default: 0};
    end else begin
      m0 = m_step(m0, 0, 255, bit_valid, bit_in, sof, clr_err);
      m1 = m_step(m1, 1, 255, bit_valid, bit_in, sof, clr_err);
      m2 = m_step(m2, 0, 3, bit_valid, bit_in, sof, clr_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u0.data", 32'(d0), 32'(m0.dout));   chk("u0.fv", 32'(fv0), 32'(m0.fv));
      chk("u0.perr", 32'(pe0), 32'(m0.perr));  chk("u0.abort", 32'(ab0), 32'(m0.abort));
      chk("u0.cnt", 32'(ec0), 32'(m0.cnt));    chk("u0.led", 32'(led0), 32'(m0.led));
      chk("u1.data", 32'(d1), 32'(m1.dout));   chk("u1.fv", 32'(fv1), 32'(m1.fv));
      chk("u1.perr", 32'(pe1), 32'(m1.perr));  chk("u1.abort", 32'(ab1), 32'(m1.abort));
      chk("u1.cnt", 32'(ec1), 32'(m1.cnt));    chk("u1.led", 32'(led1), 32'(m1.led));
      chk("u2.data", 32'(d2), 32'(m2.dout));   chk("u2.fv", 32'(fv2), 32'(m2.fv));
      chk("u2.perr", 32'(pe2), 32'(m2.perr));  chk("u2.abort", 32'(ab2), 32'(m2.abort));
      chk("u2.cnt", 32'(ec2), 32'(m2.cnt));    chk("u2.led", 32'(led2), 32'(m2.led));
    end
  end

  // One clock cycle of stimulus, applied at the falling edge
  task automatic tick(input bit bv, input bit b, input bit s, input bit clr);
    @(negedge clk);
    bit_valid = bv; bit_in = b; sof = s; clr_err = clr;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input int gap_max,
                            input bit clr_on_par, input bit chk_abort, input logic [7:0] old_d);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap_max)) tick(0, 0, 0, 0);
      tick(1, d[i], i == 0, 0);
      if (chk_abort && i == 1) begin
        chk("lit.resync_abort", 32'(ab0), 32'd1);
        chk("lit.resync_data_held", 32'(d0), 32'(old_d));
      end
    end
    repeat ($urandom_range(0, gap_max)) tick(0, 0, 0, 0);
    tick(1, p, 0, clr_on_par);
  endtask

  task automatic idle();
    tick(0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    idle();
    chk("lit.rst_data", 32'(d0), 32'd0);   chk("lit.rst_perr", 32'(pe0), 32'd0);
    chk("lit.rst_cnt", 32'(ec0), 32'd0);   chk("lit.rst_led", 32'(led0), 32'd0);

    // 0xA5 even parity 0: clean frame
    send_frame(8'hA5, 0, 0, 0, 0, 0); idle();
    chk("lit.a5_fv", 32'(fv0), 32'd1);     chk("lit.a5_data", 32'(d0), 32'hA5);
    chk("lit.model_a5", 32'(m0.dout), 32'hA5);
    chk("lit.a5_perr", 32'(pe0), 32'd0);   chk("lit.a5_cnt", 32'(ec0), 32'd0);

    // 0x01 bad, 0x03 good, then clear
    send_frame(8'h01, 0, 0, 0, 0, 0); idle();
    chk("lit.01_perr", 32'(pe0), 32'd1);   chk("lit.01_cnt", 32'(ec0), 32'd1);
    chk("lit.01_led", 32'(led0), 32'd1);   chk("lit.model_01", 32'(m0.cnt), 32'd1);
    send_frame(8'h03, 0, 0, 0, 0, 0); idle();
    chk("lit.03_perr", 32'(pe0), 32'd0);   chk("lit.03_cnt", 32'(ec0), 32'd1);
    tick(0, 0, 0, 1); idle();
    chk("lit.clr_cnt", 32'(ec0), 32'd0);   chk("lit.clr_led", 32'(led0), 32'd0);

    // Odd mode on u1
    send_frame(8'h00, 1, 0, 0, 0, 0); idle();
    chk("lit.odd_ok", 32'(pe1), 32'd0);    chk("lit.odd_ok_cnt", 32'(ec1), 32'd0);
    send_frame(8'h00, 0, 0, 0, 0, 0); idle();
    chk("lit.odd_bad", 32'(pe1), 32'd1);   chk("lit.odd_bad_cnt", 32'(ec1), 32'd1);
    chk("lit.model_odd", 32'(m1.perr), 32'd1);

    // Resync after 5 data bits
    tick(1, 1, 1, 0);
    repeat (4) tick(1, 1, 0, 0);
    send_frame(8'h3C, 0, 0, 0, 1, 8'h00); idle();
    chk("lit.3c_fv", 32'(fv0), 32'd1);     chk("lit.3c_data", 32'(d0), 32'h3C);
    chk("lit.3c_perr", 32'(pe0), 32'd0);

    // Saturating 2-bit counter on u2
    tick(0, 0, 0, 1); idle();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h01, 0, 0, 0, 0, 0); idle();
      chk("lit.sat_cnt", 32'(ec2), (k < 3) ? 32'(k + 1) : 32'd3);
      chk("lit.sat_led", 32'(led2), 32'd1);
    end
    send_frame(8'h01, 0, 0, 1, 0, 0); idle();
    chk("lit.clr_with_err", 32'(ec2), 32'd1);
    chk("lit.model_clr_err", 32'(m2.cnt), 32'd1);

    // Reset after 4 data bits
    tick(1, 1, 1, 0);
    repeat (3) tick(1, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0; bit_valid = 0; sof = 0; bit_in = 0; clr_err = 0;
    #1;
    chk("lit.mid_rst_data", 32'(d0), 32'd0);  chk("lit.mid_rst_cnt", 32'(ec0), 32'd0);
    chk("lit.mid_rst_led", 32'(led0), 32'd0); chk("lit.mid_rst_perr", 32'(pe0), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send_frame(8'hFF, 0, 0, 0, 0, 0); idle();
    chk("lit.ff_data", 32'(d0), 32'hFF);   chk("lit.ff_perr", 32'(pe0), 32'd0);

    // Gaps inside a frame, then back-to-back frames
    send_frame(8'hA5, 0, 3, 0, 0, 0); idle();
    chk("lit.gap_data", 32'(d0), 32'hA5);  chk("lit.gap_perr", 32'(pe0), 32'd0);
    send_frame(8'h5B, 0, 2, 0, 0, 0); idle();
    chk("lit.gap_bad", 32'(pe0), 32'd1);
    send_frame(8'h3C, 0, 0, 0, 0, 0);
    send_frame(8'h81, 0, 0, 0, 0, 0); idle();
    chk("lit.b2b_data", 32'(d0), 32'h81);  chk("lit.b2b_perr", 32'(pe0), 32'd0);
    repeat (3) idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Parametrised serial parity checker for the safe-communication link. It receives a bit-serial stream of frames, each made of DATA_W data bits (LSB first) followed by one parity bit. For each frame it reassembles the data word, checks parity in even or odd mode, and reports the result. It also keeps a saturating error count and drives a sticky error LED.

## Interface
- DATA_W, 8, data bits per frame (minimum 2).
- ODD, 0, parity mode: 0 = even (total ones in data plus parity is even), 1 = odd.
- CNT_W, 8, width of the error counter.

- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bit_in  in  1  serial data/parity bit, sampled when bit_valid=1.
- bit_valid  in  1  qualifies bit_in for one cycle.
- sof  in  1  start of frame; only meaningful when bit_valid=1; marks bit_in as data bit 0.
- clr_err  in  1  clears err_cnt and led.
- data_out  out  DATA_W  last completed frame's data word; held between frames.
- frame_valid  out  1  one-cycle pulse: frame complete, data_out and par_err are valid.
- par_err  out  1  parity result of the last frame (1 = mismatch); held.
- abort  out  1  one-cycle pulse: frame discarded by a new sof.
- err_cnt  out  CNT_W  count of parity errors, saturating at all-ones.
- led  out  1  sticky error indicator; set on any parity error.

## Operation
- FSM states: IDLE, DATA, PAR.
- IDLE:
  - bit_valid & sof: load bit_in into shift bit 0, set bit count to 1, go to DATA.
  - bit_valid & !sof: bit is ignored.
- DATA:
  - Each bit_valid shifts bit_in into the next position (LSB first) and increments the bit count.
  - After the DATA_W-th bit, go to PAR.
- PAR:
  - On bit_valid, compare bit_in with the expected parity, where expected = XOR(data) ^ ODD.
  - Update data_out and par_err, pulse frame_valid, go to IDLE.
- Resync: bit_valid & sof in DATA or PAR aborts the current frame.
  - Pulse abort.
  - Restart with bit_in as data bit 0 and stay in or enter DATA.
  - data_out, par_err and err_cnt are unchanged by the discarded frame.
- Error count:
  - Every frame with par_err=1 increments err_cnt (saturating) and sets led.
  - clr_err with no error in the same cycle: err_cnt <= 0, led <= 0.
  - clr_err in the same cycle as an error: err_cnt <= 1, led <= 1.
- Gaps (bit_valid=0) of any length are allowed inside a frame; state holds.

## Timing
- Reset values: state IDLE; data_out=0, frame_valid=0, par_err=0, abort=0, err_cnt=0, led=0; shift register and bit count cleared.
- Reset mid-frame discards the partial frame; the first sof after release starts a new frame.
- Latency: frame_valid, data_out, par_err, err_cnt and led all update on the clock edge that samples the parity bit. They are visible the cycle after parity bit_valid.
- abort is visible the cycle after the resyncing sof.
- Frames may be back to back: a sof in the cycle after the parity bit is accepted.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- DATA_W=8, ODD=0: send 0xA5 (LSB first) then parity 0 -> one frame_valid pulse, data_out=0xA5, par_err=0, err_cnt=0, led=0.
- DATA_W=8, ODD=0: send 0x01 with parity 0 -> par_err=1, err_cnt=1, led=1. Then 0x03 with parity 0 -> par_err=0, err_cnt=1, led=1. Then pulse clr_err -> err_cnt=0, led=0.
- DATA_W=8, ODD=1: send 0x00 with parity 1 -> par_err=0. Send 0x00 with parity 0 -> par_err=1, err_cnt=1.
- Resync: after 5 data bits, assert sof -> abort pulses, data_out unchanged. Then a full frame 0x3C with parity 0 -> frame_valid, data_out=0x3C, par_err=0.
- CNT_W=2: five bad frames -> err_cnt sequence 1,2,3,3,3, led=1. A bad frame arriving with clr_err in the same cycle -> err_cnt=1.
- Reset and gaps:
  - Assert rst_n=0 after 4 data bits -> all outputs 0. After release, a full frame 0xFF with parity 0 -> par_err=0.
  - Random bit_valid gaps inside a frame -> same result as with no gaps.
